pc_step_controller: RTL

//  Sequences the CPU program-counter enable (pcEn) from two raw front-panel buttons.

---
 rtl/pc_ctrl_pkg.sv | 12 +
 rtl/button_conditioner.sv | 59 +++++
 rtl/pc_step_controller.sv | 115 +++++++++++
 3 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types and helpers for the program-counter step/run controller.
// The state enum is also consumed by the CPU status display.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, STEP, RUN, HALTED} pc_ctrl_state_t;

    // Counter width able to hold 0..n-1 with one bit of headroom
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw button to clean level plus one-cycle rising-edge pulse:
// 2-flop synchronizer, consecutive-disagreement debounce, registered edge detect.
module button_conditioner
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            prev_q;
    logic            rise_q, rise_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    // Level flips only after DEBOUNCE_CYCLES back-to-back disagreeing samples
    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
        rise_d = level_q & ~prev_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            level_q  <= 1'b0;
            db_cnt_q <= '0;
            prev_q   <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
            prev_q   <= level_q;
            rise_q   <= rise_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = rise_q;

endmodule

// File: rtl/pc_step_controller.sv
// Sole driver of the CPU pcEn: single-step and free-run sequencing from two
// front-panel buttons, with a core halt request that parks execution.
module pc_step_controller
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned RATE_DIV        = 50_000_000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             step_btn,
    input  logic             run_btn,
    input  logic             halt_req,
    output logic             pcEn,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] issued_count
);

    localparam int unsigned RATE_W = cnt_width(RATE_DIV);
    localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(RATE_DIV - 1);

    logic step_p, run_p;
    logic step_level_unused, run_level_unused;

    pc_ctrl_state_t    state_q, state_d;
    logic [RATE_W-1:0] rate_cnt_q, rate_cnt_d;
    logic              pc_en_q, pc_en_d;
    logic              running_q, running_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  issued_q, issued_d;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
        .clock      (clock),
        .reset      (reset),
        .raw        (step_btn),
        .level      (step_level_unused),
        .rise_pulse (step_p)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
        .clock      (clock),
        .reset      (reset),
        .raw        (run_btn),
        .level      (run_level_unused),
        .rise_pulse (run_p)
    );

    always_comb begin
        state_d    = state_q;
        rate_cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (run_p) begin
                    state_d = RUN;
                end else if (step_p) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                state_d = IDLE;
            end
            RUN: begin
                // Halt outranks a simultaneous run toggle
                if (halt_req) begin
                    state_d = HALTED;
                end else if (run_p) begin
                    state_d = IDLE;
                end else begin
                    rate_cnt_d = (rate_cnt_q == RATE_LAST) ? '0 : rate_cnt_q + RATE_W'(1);
                end
            end
            HALTED: begin
                if (!halt_req && (step_p || run_p)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A rate tick in the cycle RUN is left is swallowed
        pc_en_d   = (state_q == STEP) ||
                    ((state_q == RUN) && (state_d == RUN) && (rate_cnt_q == RATE_LAST));
        running_d = (state_d == RUN);
        halted_d  = (state_d == HALTED);
        issued_d  = issued_q + CNT_W'(pc_en_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rate_cnt_q <= '0;
            pc_en_q    <= 1'b0;
            running_q  <= 1'b0;
            halted_q   <= 1'b0;
            issued_q   <= '0;
        end else begin
            state_q    <= state_d;
            rate_cnt_q <= rate_cnt_d;
            pc_en_q    <= pc_en_d;
            running_q  <= running_d;
            halted_q   <= halted_d;
            issued_q   <= issued_d;
        end
    end

    assign pcEn         = pc_en_q;
    assign running      = running_q;
    assign halted       = halted_q;
    assign issued_count = issued_q;

endmodule
